// File: rtl/output_bram_axis_reader.sv
// output_bram_axis_reader: drains one output BRAM row onto AXI4-Stream.
// Optional OUT_RELU_EN: clamp negative words to zero on FIFO write.

module output_bram_axis_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Start_row,
    input  logic [ADDR_WIDTH-1:0] Base_addr,
    input  logic [LEN_WIDTH-1:0]  Row_length,
    input  logic                  Last_row,
    output logic                  enb_output_BRAM,
    output logic [ADDR_WIDTH-1:0] addrb_output_BRAM,
    input  logic [DATA_WIDTH-1:0] doutb_output_BRAM,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  Busy,
    output logic                  Row_done
);

    typedef enum logic [1:0] {
        S_Idle,
        S_Read,
        S_Drain,
        S_Done
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  last_q, last_d;
    logic [LEN_WIDTH-1:0]  issue_q, issue_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic                  inflight_q, inflight_d;
    logic [2:0]            count_q, count_d;
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_q [4];

    logic                  push;
    logic                  pop;
    logic                  room;
    logic                  last_beat;
    logic [LEN_WIDTH-1:0]  issue_inc;
    logic [DATA_WIDTH-1:0] fifo_wdata;

`ifdef OUT_RELU_EN
    assign fifo_wdata = doutb_output_BRAM[DATA_WIDTH-1] ? '0 : doutb_output_BRAM;
`else
    assign fifo_wdata = doutb_output_BRAM;
`endif

    // A read issued last cycle returns its word now; that is the push.
    assign push      = inflight_q;
    assign m_axis_tvalid = (count_q != 3'd0);
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_q[rd_ptr_q] : '0;
    assign room      = (count_q + 3'(inflight_q)) < 3'd4;
    assign last_beat = (beat_q == len_q - LEN_WIDTH'(1));
    assign m_axis_tlast  = m_axis_tvalid & last_q & last_beat;
    assign issue_inc = issue_q + LEN_WIDTH'(1);

    // Next state, read issue and row bookkeeping.
    always_comb begin
        state_d           = state_q;
        base_d            = base_q;
        len_d             = len_q;
        last_d            = last_q;
        issue_d           = issue_q;
        beat_d            = pop ? beat_q + LEN_WIDTH'(1) : beat_q;
        inflight_d        = 1'b0;
        enb_output_BRAM   = 1'b0;
        addrb_output_BRAM = '0;
        Busy              = 1'b1;
        Row_done          = 1'b0;
        unique case (state_q)
            S_Idle: begin
                Busy = 1'b0;
                if (Start_row) begin
                    base_d  = Base_addr;
                    len_d   = Row_length;
                    last_d  = Last_row;
                    issue_d = '0;
                    beat_d  = '0;
                    state_d = (Row_length == '0) ? S_Done : S_Read;
                end
            end
            S_Read: begin
                if (room) begin
                    enb_output_BRAM   = 1'b1;
                    addrb_output_BRAM = base_q + issue_q[ADDR_WIDTH-1:0];
                    inflight_d        = 1'b1;
                    issue_d           = issue_inc;
                    if (issue_inc == len_q) begin
                        state_d = S_Drain;
                    end
                end
            end
            S_Drain: begin
                if (pop && last_beat) begin
                    state_d = S_Done;
                end
            end
            S_Done: begin
                Row_done = 1'b1;
                state_d  = S_Idle;
            end
            default: state_d = S_Idle;
        endcase
    end

    // Prefetch FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // State and control registers; reset aborts and flushes the row.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= S_Idle;
            base_q     <= '0;
            len_q      <= '0;
            last_q     <= 1'b0;
            issue_q    <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            last_q     <= last_d;
            issue_q    <= issue_d;
            beat_q     <= beat_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= fifo_wdata;
        end
    end

endmodule

// File: tb/tb_output_bram_axis_reader.sv
// tb_output_bram_axis_reader: random and directed rows against a queue model.
// Build with +define+OUT_RELU_EN to exercise the ReLU variant.

module tb_output_bram_axis_reader;

    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int LW    = 15;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          Reset;
    logic          Start_row;
    logic [AW-1:0] Base_addr;
    logic [LW-1:0] Row_length;
    logic          Last_row;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic          Busy;
    logic          Row_done;

    logic [DW-1:0] mem [DEPTH];
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;

    logic [DW-1:0] got_d [$];
    bit            got_l [$];
    int            beat_cyc [$];
    logic [AW-1:0] addr_q [$];
    int            enb_cyc [$];
    int            issued_m = 0;
    int            popped_m = 0;
    int            maxout = 0;
    int            rdone_cnt = 0;
    int            rdone_cyc = 0;
    int            busy_cnt = 0;
    int            viol = 0;
    int            tv_cnt = 0;
    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic [DW-1:0] pd = '0;

    output_bram_axis_reader dut (
        .clk               (clk),
        .Reset             (Reset),
        .Start_row         (Start_row),
        .Base_addr         (Base_addr),
        .Row_length        (Row_length),
        .Last_row          (Last_row),
        .enb_output_BRAM   (enb),
        .addrb_output_BRAM (addrb),
        .doutb_output_BRAM (doutb),
        .m_axis_tdata      (tdata),
        .m_axis_tvalid     (tvalid),
        .m_axis_tlast      (tlast),
        .m_axis_tready     (tready),
        .Busy              (Busy),
        .Row_done          (Row_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (enb) doutb <= mem[addrb];
    end

    initial begin
        int out;
        forever begin
            @(negedge clk);
            if (Reset) begin
                issued_m = popped_m;
                pv = 1'b0;
            end else begin
                out = issued_m + (enb ? 1 : 0) - popped_m;
                if (out > maxout) maxout = out;
                if (tvalid) tv_cnt++;
                if (pv && !pr && (!tvalid || tdata != pd)) viol++;
                if (tvalid && tready) begin
                    got_d.push_back(tdata);
                    got_l.push_back(tlast);
                    beat_cyc.push_back(cyc);
                    popped_m++;
                end
                if (enb) begin
                    addr_q.push_back(addrb);
                    enb_cyc.push_back(cyc);
                    issued_m++;
                end
                if (Row_done) begin
                    rdone_cnt++;
                    rdone_cyc = cyc;
                end
                if (Busy) busy_cnt++;
                pv = tvalid;
                pr = tready;
                pd = tdata;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input int a);
        logic [DW-1:0] w;
        w = mem[AW'(a)];
`ifdef OUT_RELU_EN
        if ($signed(w) < 0) w = '0;
`endif
        return w;
    endfunction

    function automatic bit pick(input int mode, input int n);
        case (mode)
            0:       return 1'b1;
            1:       return (n % 4 == 0) || (n % 4 == 3);
            default: return $urandom_range(3) != 0;
        endcase
    endfunction

    task automatic check_zero(input string pfx);
        check({pfx, "_enb"}, int'(enb), 0);
        check({pfx, "_addrb"}, int'(addrb), 0);
        check({pfx, "_tdata"}, int'(tdata), 0);
        check({pfx, "_tvalid"}, int'(tvalid), 0);
        check({pfx, "_tlast"}, int'(tlast), 0);
        check({pfx, "_busy"}, int'(Busy), 0);
        check({pfx, "_rdone"}, int'(Row_done), 0);
    endtask

    task automatic run_row(input int base, input int len, input bit last,
                           input int mode, input bit inject);
        int t0, sb, sa, sr, sbusy, sv, stv, n;
        bit done;
        bool_ok: begin end
        sb    = got_d.size();
        sa    = addr_q.size();
        sr    = rdone_cnt;
        sbusy = busy_cnt;
        sv    = viol;
        stv   = tv_cnt;
        @(posedge clk); #1;
        Start_row  = 1'b1;
        Base_addr  = AW'(base);
        Row_length = LW'(len);
        Last_row   = last;
        tready     = pick(mode, 0);
        t0         = cyc;
        n          = 0;
        done       = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            n++;
            Start_row = inject && (n == 2);
            if (inject) begin
                Base_addr  = 14'd777;
                Row_length = 15'd5;
                Last_row   = 1'b1;
            end
            tready = pick(mode, n);
            @(negedge clk); #1;
            if (rdone_cnt != sr || n > 40 * len + 50) done = 1'b1;
        end
        Start_row = 1'b0;
        tready    = 1'b1;
        check("rows", rdone_cnt - sr, 1);
        check("beats", got_d.size() - sb, len);
        check("reads", addr_q.size() - sa, len);
        for (int i = 0; i < len; i++) begin
            if (sb + i < got_d.size()) begin
                check("data", int'(got_d[sb+i]), int'(exp_word(base + i)));
                check("tlast", int'(got_l[sb+i]), int'(last && i == len - 1));
            end
            if (sa + i < addr_q.size())
                check("addr", int'(addr_q[sa+i]), (base + i) % DEPTH);
        end
        check("busy_cycles", busy_cnt - sbusy, rdone_cyc - t0);
        check("hold", viol - sv, 0);
        check("maxout", int'(maxout > 4), 0);
        if (len == 0) check("tvalid_zero", tv_cnt - stv, 0);
        if (mode == 0) begin
            check("done_lat", rdone_cyc - t0, (len == 0) ? 1 : len + 3);
            if (len > 0 && got_d.size() - sb == len && addr_q.size() - sa == len) begin
                check("enb0_lat", enb_cyc[sa] - t0, 1);
                check("beat0_lat", beat_cyc[sb] - t0, 3);
                check("beatN_lat", beat_cyc[sb+len-1] - t0, len + 2);
            end
        end
        if (inject) begin
            repeat (3) @(negedge clk);
            #1;
            check("ignored_start", addr_q.size() - sa, len);
            check("idle_after", int'(Busy), 0);
        end
    endtask

    initial begin
        int sb, sr, n, s;
        logic [DW-1:0] e0;
        Reset      = 1'b1;
        Start_row  = 1'b0;
        Base_addr  = '0;
        Row_length = '0;
        Last_row   = 1'b0;
        tready     = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[AW'(i)] = $urandom;
        for (int i = 0; i < 8; i++) mem[AW'(i)] = DW'(i + 1);
        mem[AW'(300)] = 32'h8000_0005;
        mem[AW'(301)] = 32'h0000_0007;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        #1 Reset = 1'b0;

        run_row(0, 8, 1'b0, 0, 1'b0);
        run_row(200, 16, 1'b1, 1, 1'b0);
        run_row(DEPTH - 2, 4, 1'b0, 0, 1'b1);
        run_row(50, 0, 1'b1, 0, 1'b0);

        sb = got_d.size();
        sr = rdone_cnt;
        @(posedge clk); #1;
        Start_row  = 1'b1;
        Base_addr  = 14'd1000;
        Row_length = 15'd10;
        Last_row   = 1'b0;
        tready     = 1'b1;
        n = 0;
        while (got_d.size() - sb < 3 && n < 200) begin
            @(posedge clk); #1;
            Start_row = 1'b0;
            @(negedge clk); #1;
            n++;
        end
        tready = 1'b0;
        check("pre_rst_beats", got_d.size() - sb, 3);
        @(posedge clk); #1;
        Reset = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0;
        @(negedge clk); #1;
        check_zero("midrst");
        repeat (10) @(negedge clk);
        #1;
        check("rst_no_done", rdone_cnt - sr, 0);
        check("rst_no_beats", got_d.size() - sb, 3);
        tready = 1'b1;
        run_row(1100, 2, 1'b1, 0, 1'b0);

        s = got_d.size();
        run_row(300, 2, 1'b1, 0, 1'b0);
`ifdef OUT_RELU_EN
        e0 = '0;
`else
        e0 = 32'h8000_0005;
`endif
        check("relu_n", got_d.size() - s, 2);
        if (got_d.size() - s == 2) begin
            check("relu_w0", int'(got_d[s]), int'(e0));
            check("relu_w1", int'(got_d[s+1]), 7);
        end

        for (int r = 0; r < 8; r++) begin
            run_row(int'($urandom_range(DEPTH - 1)), int'($urandom_range(24)),
                    bit'($urandom_range(1)), 2, 1'b0);
        end
        run_row(DEPTH - 20, 40, 1'b1, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
